round_scheduler: RTL and testbench
==================================

ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 Parameters (name, default, meaning): BORAD_WIDTH, 10, board side; LOG2_BORAD_WIDTH, 4, coordinate width; LOG2_MAX_TROOP, 9, troop width; LOG2_MAX_ROUND, 12, round counter is LOG2_MAX_ROUND+1 bits; TICKS_PER_TURN, 50000000, turn length in clock cycles (>=2); GROWTH_PERIOD, 25, territory growth interval in rounds (>=1).
REQ-002 Clock and reset SHALL be: clock  in  1  single clock, all logic on rising edge; reset  in  1  synchronous, active-low.
REQ-003 Inputs SHALL be: start  in  1  game-start pulse; move_done  in  1  current player's move settled; game_over  in  1  level, winner decided; rd_owner  in  3  owner of addressed cell; rd_piece  in  2  piece type of addressed cell (0 TERRITORY, 1 MOUNTAIN, 2 CROWN, 3 CITY); rd_troop  in  LOG2_MAX_TROOP  troop of addressed cell.
REQ-004 Outputs SHALL be: cell_h, cell_v  out  LOG2_BORAD_WIDTH  sweep address; cell_we  out  1  troop write strobe; wr_troop  out  LOG2_MAX_TROOP  write data; current_player  out  3  1 RED, 2 BLUE; round  out  LOG2_MAX_ROUND+1; logic_enable  out  1  game logic may process operations; turn_start  out  1  one-cycle pulse, cursor to crown; timeout  out  1  one-cycle pulse, turn expired; busy  out  1  sweep in progress.

Function
REQ-005 FSM states SHALL be IDLE, TURN, SWITCH, SWEEP_RD, SWEEP_WR, OVER.
REQ-006 IDLE: logic_enable=0; start=1 -> TURN next cycle with current_player=RED, round=1, turn counter=TICKS_PER_TURN-1.
REQ-007 start SHALL be ignored in every state except IDLE.
REQ-008 turn_start SHALL be 1 exactly in the first cycle of every TURN entry; logic_enable SHALL be 1 only while in TURN.
REQ-009 TURN: counter decrements every cycle; TURN lasts at most TICKS_PER_TURN cycles.
REQ-010 TURN, move_done=1 -> SWITCH; counter==0 without move_done -> SWITCH with timeout=1 during that SWITCH cycle; both in same cycle -> single SWITCH, timeout=0.
REQ-011 SWITCH (one cycle): current_player toggles RED<->BLUE; counter reloads TICKS_PER_TURN-1; if old player was BLUE, round increments (saturating at all-ones) and next state is SWEEP_RD with cell_h=cell_v=0; otherwise next state is TURN.
REQ-012 Sweep SHALL visit cells in order v-major: h 0..BORAD_WIDTH-1 inner, v 0..BORAD_WIDTH-1 outer, two cycles per cell, total 2*BORAD_WIDTH^2 cycles; busy=1 throughout.
REQ-013 SWEEP_RD drives address; cell read data is valid in the following SWEEP_WR cycle (1-cycle read latency) with the address held.
REQ-014 SWEEP_WR: cell_we=1 with wr_troop=rd_troop+1 iff rd_owner!=0, rd_troop<2^LOG2_MAX_TROOP-1, and (rd_piece in {CROWN, CITY} or (rd_piece==TERRITORY and round mod GROWTH_PERIOD==0)); else cell_we=0. MOUNTAIN never grows.
REQ-015 Troop SHALL saturate at 2^LOG2_MAX_TROOP-1 (no write at maximum, no wrap).
REQ-016 After SWEEP_WR of last cell -> TURN; else SWEEP_RD of next cell.
REQ-017 game_over=1 in any state except IDLE -> OVER next cycle; cell_we forced 0 that cycle; partial sweep abandoned.
REQ-018 OVER: all strobes 0, logic_enable=0, current_player and round held; leave only via reset.
REQ-019 move_done outside TURN SHALL be ignored.

Reset
REQ-020 reset=0 at a rising edge SHALL, in any state including mid-sweep, force IDLE, current_player=RED, round=1, cell_h=cell_v=0, wr_troop=0, cell_we=0, logic_enable=0, turn_start=0, timeout=0, busy=0, counter=0.
REQ-021 reset SHALL take priority over start, move_done and game_over.

Verification (TICKS_PER_TURN=8, GROWTH_PERIOD=2, BORAD_WIDTH=10)
REQ-022 start at cycle 0 -> cycle 1: TURN, turn_start=1, logic_enable=1, current_player=1; no move_done -> SWITCH at cycle 9 with timeout=1, player=2, turn_start at cycle 10.
REQ-023 BLUE move_done -> round 1->2, busy=1 for 200 cycles, cell (2,3) RED CROWN troop 0x57 written 0x58, owned TERRITORY written +1 (round 2 even), NPC and MOUNTAIN cells cell_we=0, then TURN with player=1.
REQ-024 Round 3 sweep: owned TERRITORY not written, CITY troop 0x43 -> 0x44; owned CROWN at 511 -> cell_we=0.
REQ-025 move_done and counter==0 same cycle -> exactly one switch, timeout=0.
REQ-026 reset low at sweep cell 57 -> next cycle all outputs at REQ-020 values; game_over mid-TURN -> OVER, logic_enable=0, later start ignored.

Source files
------------

// File: rtl/round_scheduler.sv
// Turn/round sequencer for a two-player board game: runs timed turns, alternates
// players, and after each full round sweeps the board to grow troop counts.
module round_scheduler #(
    parameter int unsigned BORAD_WIDTH      = 10,
    parameter int unsigned LOG2_BORAD_WIDTH = 4,
    parameter int unsigned LOG2_MAX_TROOP   = 9,
    parameter int unsigned LOG2_MAX_ROUND   = 12,
    parameter int unsigned TICKS_PER_TURN   = 50000000,
    parameter int unsigned GROWTH_PERIOD    = 25
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        move_done,
    input  logic                        game_over,
    input  logic [2:0]                  rd_owner,
    input  logic [1:0]                  rd_piece,
    input  logic [LOG2_MAX_TROOP-1:0]   rd_troop,
    output logic [LOG2_BORAD_WIDTH-1:0] cell_h,
    output logic [LOG2_BORAD_WIDTH-1:0] cell_v,
    output logic                        cell_we,
    output logic [LOG2_MAX_TROOP-1:0]   wr_troop,
    output logic [2:0]                  current_player,
    output logic [LOG2_MAX_ROUND:0]     round,
    output logic                        logic_enable,
    output logic                        turn_start,
    output logic                        timeout,
    output logic                        busy
);

    localparam int unsigned CNT_W   = (TICKS_PER_TURN > 1) ? $clog2(TICKS_PER_TURN) : 1;
    localparam int unsigned RND_W   = LOG2_MAX_ROUND + 1;
    localparam int unsigned COORD_W = LOG2_BORAD_WIDTH;
    localparam int unsigned TROOP_W = LOG2_MAX_TROOP;

    localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(TICKS_PER_TURN - 1);
    localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(BORAD_WIDTH - 1);
    localparam logic [TROOP_W-1:0] TROOP_MAX  = '1;
    localparam logic [RND_W-1:0]   ROUND_MAX  = '1;

    localparam logic [2:0] PLAYER_RED  = 3'd1;
    localparam logic [2:0] PLAYER_BLUE = 3'd2;

    localparam logic [1:0] PIECE_TERRITORY = 2'd0;
    localparam logic [1:0] PIECE_CROWN     = 2'd2;
    localparam logic [1:0] PIECE_CITY      = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TURN     = 3'd1,
        SWITCH   = 3'd2,
        SWEEP_RD = 3'd3,
        SWEEP_WR = 3'd4,
        OVER     = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [2:0]           player_nxt;
    logic [RND_W-1:0]     round_nxt;
    logic [COORD_W-1:0]   h_nxt;
    logic [COORD_W-1:0]   v_nxt;
    logic                 enable_nxt;
    logic                 turn_start_nxt;
    logic                 timeout_nxt;
    logic                 busy_nxt;

    logic                 territory_due_c;
    logic                 grow_c;

    // Growth rule for the cell currently presented on the read port
    assign territory_due_c = ((32'(round) % GROWTH_PERIOD) == 32'd0);
    assign grow_c = (rd_owner != 3'd0) && (rd_troop != TROOP_MAX) &&
                    ((rd_piece == PIECE_CROWN) || (rd_piece == PIECE_CITY) ||
                     ((rd_piece == PIECE_TERRITORY) && territory_due_c));

    // Next-state, next-register values, and the combinational write port
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        player_nxt  = current_player;
        round_nxt   = round;
        h_nxt       = cell_h;
        v_nxt       = cell_v;
        timeout_nxt = 1'b0;
        cell_we     = 1'b0;
        wr_troop    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = TURN;
                    cnt_nxt    = CNT_RELOAD;
                    player_nxt = PLAYER_RED;
                    round_nxt  = RND_W'(1);
                end
            end
            TURN: begin
                if (move_done || (cnt == '0)) begin
                    state_nxt   = SWITCH;
                    timeout_nxt = !move_done;
                    cnt_nxt     = CNT_RELOAD;
                    player_nxt  = (current_player == PLAYER_RED) ? PLAYER_BLUE : PLAYER_RED;
                    if (current_player == PLAYER_BLUE) begin
                        round_nxt = (round == ROUND_MAX) ? round : round + RND_W'(1);
                        h_nxt     = '0;
                        v_nxt     = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SWITCH: begin
                // Player already toggled: RED now means BLUE just closed the round
                state_nxt = (current_player == PLAYER_RED) ? SWEEP_RD : TURN;
            end
            SWEEP_RD: begin
                state_nxt = SWEEP_WR;
            end
            SWEEP_WR: begin
                cell_we = grow_c;
                if ((cell_h == LAST_COORD) && (cell_v == LAST_COORD)) begin
                    state_nxt = TURN;
                end else begin
                    state_nxt = SWEEP_RD;
                    if (cell_h == LAST_COORD) begin
                        h_nxt = '0;
                        v_nxt = cell_v + COORD_W'(1);
                    end else begin
                        h_nxt = cell_h + COORD_W'(1);
                    end
                end
            end
            OVER: begin
                state_nxt = OVER;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Game end freezes everything and kills any in-flight write
        if (game_over && (state != IDLE)) begin
            state_nxt   = OVER;
            cnt_nxt     = cnt;
            player_nxt  = current_player;
            round_nxt   = round;
            h_nxt       = cell_h;
            v_nxt       = cell_v;
            timeout_nxt = 1'b0;
            cell_we     = 1'b0;
        end

        if (!reset) begin
            cell_we = 1'b0;
        end

        wr_troop = cell_we ? (rd_troop + TROOP_W'(1)) : '0;

        enable_nxt     = (state_nxt == TURN);
        turn_start_nxt = (state_nxt == TURN) && (state != TURN);
        busy_nxt       = (state_nxt == SWEEP_RD) || (state_nxt == SWEEP_WR);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            current_player <= PLAYER_RED;
            round          <= RND_W'(1);
            cell_h         <= '0;
            cell_v         <= '0;
            logic_enable   <= 1'b0;
            turn_start     <= 1'b0;
            timeout        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            current_player <= player_nxt;
            round          <= round_nxt;
            cell_h         <= h_nxt;
            cell_v         <= v_nxt;
            logic_enable   <= enable_nxt;
            turn_start     <= turn_start_nxt;
            timeout        <= timeout_nxt;
            busy           <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_round_scheduler.sv
// Randomized bench for round_scheduler: board memory with 1-cycle read latency and
// a spec-level model of turn timing and per-round troop growth.
module tb_round_scheduler;

    localparam int W     = 10;
    localparam int LBW   = 4;
    localparam int LT    = 9;
    localparam int LR    = 12;
    localparam int TPT   = 8;
    localparam int GP    = 2;
    localparam int NCELL = W * W;
    localparam int TMAX  = (1 << LT) - 1;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           move_done;
    logic           game_over;
    logic [2:0]     rd_owner;
    logic [1:0]     rd_piece;
    logic [LT-1:0]  rd_troop;
    logic [LBW-1:0] cell_h;
    logic [LBW-1:0] cell_v;
    logic           cell_we;
    logic [LT-1:0]  wr_troop;
    logic [2:0]     current_player;
    logic [LR:0]    round;
    logic           logic_enable;
    logic           turn_start;
    logic           timeout;
    logic           busy;

    round_scheduler #(
        .BORAD_WIDTH(W), .LOG2_BORAD_WIDTH(LBW), .LOG2_MAX_TROOP(LT),
        .LOG2_MAX_ROUND(LR), .TICKS_PER_TURN(TPT), .GROWTH_PERIOD(GP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .move_done(move_done),
        .game_over(game_over), .rd_owner(rd_owner), .rd_piece(rd_piece),
        .rd_troop(rd_troop), .cell_h(cell_h), .cell_v(cell_v), .cell_we(cell_we),
        .wr_troop(wr_troop), .current_player(current_player), .round(round),
        .logic_enable(logic_enable), .turn_start(turn_start), .timeout(timeout),
        .busy(busy)
    );

    always #5 clock = ~clock;

    logic [2:0]    owner_m    [NCELL];
    logic [1:0]    piece_m    [NCELL];
    logic [LT-1:0] init_troop [NCELL];
    logic [LT-1:0] troop_m    [NCELL];
    int            load_seq = 0;
    int            last_seq = 0;

    // Board memory: registered read, write on cell_we, bulk load on request
    always @(posedge clock) begin
        int a;
        a = int'(cell_v) * W + int'(cell_h);
        if (a >= NCELL) a = 0;
        rd_owner <= owner_m[a];
        rd_piece <= piece_m[a];
        rd_troop <= troop_m[a];
        if (load_seq != last_seq) begin
            troop_m  <= init_troop;
            last_seq <= load_seq;
        end else if (cell_we) begin
            troop_m[a] <= wr_troop;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit grows(input logic [2:0] o, input logic [1:0] p,
                                 input logic [LT-1:0] t, input int rnd);
        if (o == 3'd0 || int'(t) == TMAX) return 1'b0;
        if (p == 2'd2 || p == 2'd3) return 1'b1;
        return (p == 2'd0) && (rnd % GP == 0);
    endfunction

    task automatic set_cell(input int i, input int o, input int p, input int t);
        owner_m[i]    = 3'(o);
        piece_m[i]    = 2'(p);
        init_troop[i] = LT'(t);
    endtask

    task automatic load_board();
        for (int i = 0; i < NCELL; i++) begin
            owner_m[i]    = 3'($urandom_range(0, 2));
            piece_m[i]    = 2'($urandom_range(0, 3));
            init_troop[i] = ($urandom_range(0, 7) == 0) ? LT'(TMAX) : LT'($urandom_range(0, TMAX));
        end
        set_cell(3 * W + 2, 1, 2, 'h57);
        set_cell(45, 2, 3, 'h43);
        set_cell(67, 1, 2, TMAX);
        set_cell(11, 1, 1, 20);
        set_cell(12, 0, 0, 7);
        set_cell(13, 1, 0, 30);
        set_cell(0, 2, 3, 5);
        load_seq++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, {cell_h, cell_v}, 0);
        check({tag, "_wr"}, {cell_we, wr_troop}, 0);
        check({tag, "_prd"}, {current_player, round}, {3'd1, 13'd1});
        check({tag, "_flags"}, {logic_enable, turn_start, timeout, busy}, 0);
    endtask

    // Called at the first TURN cycle; returns in the SWITCH cycle
    task automatic play_turn(input int pl, input int done_at, input int rnd_after);
        int bad = 0;
        for (int k = 0; k < TPT; k++) begin
            if (logic_enable !== 1'b1 || turn_start !== 1'(k == 0) ||
                int'(current_player) != pl || busy !== 1'b0) bad++;
            if (k == done_at) begin
                move_done = 1'b1;
                @(negedge clock);
                move_done = 1'b0;
                break;
            end
            @(negedge clock);
        end
        check("turn_body", bad, 0);
        check("sw_timeout", timeout, (done_at < 0) ? 1 : 0);
        check("sw_player", current_player, (pl == 1) ? 2 : 1);
        check("sw_round", round, rnd_after);
        check("sw_enable", {logic_enable, turn_start, busy}, 0);
    endtask

    task automatic expect_blue_start();
        @(negedge clock);
        check("blue_start", {turn_start, logic_enable, current_player, busy}, {1'b1, 1'b1, 3'd2, 1'b0});
    endtask

    // Called at the first sweep cycle; stop_k >= 0 returns early in that cycle
    task automatic sweep(input int rnd, input int stop_k);
        logic [LT-1:0] snap [NCELL];
        int bad = 0;
        int c;
        bit g;
        snap = troop_m;
        for (int k = 0; k < 2 * NCELL; k++) begin
            if (k == stop_k) begin
                check("sweep_part", bad, 0);
                return;
            end
            c = k / 2;
            if (busy !== 1'b1 || int'(cell_h) != c % W || int'(cell_v) != c / W ||
                logic_enable !== 1'b0) bad++;
            if (k % 2 == 0) begin
                if (cell_we !== 1'b0) bad++;
            end else begin
                g = grows(owner_m[c], piece_m[c], snap[c], rnd);
                if (cell_we !== g) bad++;
                if (g && wr_troop !== LT'(snap[c] + 1)) bad++;
            end
            move_done = (k == 50);
            start     = (k == 51);
            @(negedge clock);
        end
        move_done = 1'b0;
        start     = 1'b0;
        check("sweep_seq", bad, 0);
        check("sweep_exit", {busy, turn_start, logic_enable, current_player}, {1'b0, 1'b1, 1'b1, 3'd1});
        for (int i = 0; i < NCELL; i++)
            check("cell_troop", troop_m[i],
                  LT'(snap[i] + (grows(owner_m[i], piece_m[i], snap[i], rnd) ? 1 : 0)));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; move_done = 1'b0; game_over = 1'b0;
        load_board();
        repeat (3) @(negedge clock);
        check_reset_state("rst0");
        reset = 1'b1;
        @(negedge clock);
        check("idle_hold", {logic_enable, turn_start, busy}, 0);

        // Round 1: RED times out, BLUE moves, sweep with territory growth
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("first_turn", {turn_start, logic_enable, current_player, round}, {1'b1, 1'b1, 3'd1, 13'd1});
        play_turn(1, -1, 1);
        expect_blue_start();
        play_turn(2, $urandom_range(0, 6), 2);
        @(negedge clock);
        sweep(2, -1);
        check("crown_23", troop_m[3 * W + 2], 'h58);
        check("terr_r2", troop_m[13], 31);
        check("mountain", troop_m[11], 20);
        check("npc", troop_m[12], 7);

        // Round 2: BLUE's move lands exactly as the counter expires
        load_board();
        play_turn(1, $urandom_range(0, 6), 2);
        expect_blue_start();
        play_turn(2, TPT - 1, 3);
        @(negedge clock);
        sweep(3, -1);
        check("city_r3", troop_m[45], 'h44);
        check("crown_max", troop_m[67], TMAX);
        check("terr_r3", troop_m[13], 30);

        // Round 3: reset in the middle of the sweep
        play_turn(1, $urandom_range(0, 6), 3);
        expect_blue_start();
        play_turn(2, $urandom_range(0, 6), 4);
        @(negedge clock);
        sweep(4, 2 * 57);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("rst57");
        reset = 1'b1;

        // New game: game_over during a write cycle of the sweep
        load_board();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("restart", {turn_start, current_player, round}, {1'b1, 3'd1, 13'd1});
        play_turn(1, $urandom_range(0, 6), 1);
        expect_blue_start();
        play_turn(2, $urandom_range(0, 6), 2);
        @(negedge clock);
        sweep(2, 1);
        check("we_pre", cell_we, 1);
        game_over = 1'b1;
        #1;
        check("go_we", {cell_we, wr_troop}, 0);
        @(negedge clock);
        game_over = 1'b0;
        check("over_flags", {logic_enable, busy, turn_start, timeout}, 0);
        check("over_hold", {current_player, round}, {3'd1, 13'd2});
        check("over_mem", troop_m[0], 5);
        start = 1'b1; move_done = 1'b1;
        @(negedge clock);
        start = 1'b0; move_done = 1'b0;
        repeat (4) @(negedge clock);
        check("over_stay", {logic_enable, turn_start, busy, current_player, round},
              {3'b000, 3'd1, 13'd2});

        // game_over in the middle of a turn
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("rst2");
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_turn", logic_enable, 1);
        game_over = 1'b1;
        @(negedge clock);
        game_over = 1'b0;
        check("go_turn", {logic_enable, turn_start, timeout, busy}, 0);
        check("go_turn_hold", {current_player, round}, {3'd1, 13'd1});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (TPT + 2) @(negedge clock);
        check("go_turn_stay", {logic_enable, turn_start, timeout, busy, current_player},
              {4'b0000, 3'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
